// File: rtl/matrix_mac_sequencer.sv
// Control sequencer for one 4x4 matrix multiply-accumulate job: clears the MAC,
// streams K tile-pair reads, waits for the MAC pipeline to drain, then hands off the result.
module matrix_mac_sequencer #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned K_WIDTH     = 8,
  parameter int unsigned MAC_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_a_base_i,
  input  logic [ADDR_WIDTH-1:0] cmd_b_base_i,
  input  logic [K_WIDTH-1:0]    cmd_k_tiles_i,
  output logic                  rd_req_valid_o,
  input  logic                  rd_req_ready_i,
  output logic [ADDR_WIDTH-1:0] rd_addr_a_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_b_o,
  input  logic                  rd_data_valid_i,
  output logic                  mac_clear_o,
  output logic                  mac_enable_o,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic                  busy_o,
  output logic                  proto_err_o
);

  localparam int unsigned LAT_W    = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
  localparam int unsigned LAT_LAST = (MAC_LATENCY > 0) ? MAC_LATENCY - 1 : 0;

  if (DATA_WIDTH == 0 || ADDR_WIDTH == 0 || K_WIDTH == 0) begin : g_param_check
    $error("matrix_mac_sequencer: widths must be non-zero");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_DRAIN,
    S_OUTPUT
  } state_e;

  state_e                state_q, state_d;
  logic [K_WIDTH-1:0]    k_q, k_d;
  logic [K_WIDTH-1:0]    issue_cnt_q, issue_cnt_d;
  logic [K_WIDTH-1:0]    ret_cnt_q, ret_cnt_d;
  logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
  logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
  logic                  proto_err_q, proto_err_d;
  logic                  drop_q, drop_d;
  logic                  rd_req_valid_q, mac_clear_q, res_valid_q, busy_q, cmd_ready_q;
  logic                  mac_en_c;

  // A return is only legal while the MAC is listening and a request is outstanding.
  assign mac_en_c = rd_data_valid_i
                    && (state_q == S_ISSUE || state_q == S_DRAIN)
                    && (ret_cnt_q != issue_cnt_q);

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    addr_a_d    = addr_a_q;
    addr_b_d    = addr_b_q;
    proto_err_d = proto_err_q;
    drop_d      = drop_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          k_d         = cmd_k_tiles_i;
          addr_a_d    = cmd_a_base_i;
          addr_b_d    = cmd_b_base_i;
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
          lat_cnt_d   = '0;
          drop_d      = 1'b0;
          state_d     = S_CLEAR;
        end
      end
      S_CLEAR: begin
        state_d = (k_q != '0) ? S_ISSUE : S_DRAIN;
      end
      S_ISSUE: begin
        if (rd_req_ready_i) begin
          issue_cnt_d = issue_cnt_q + K_WIDTH'(1);
          addr_a_d    = addr_a_q + ADDR_WIDTH'(1);
          addr_b_d    = addr_b_q + ADDR_WIDTH'(1);
          if (issue_cnt_d == k_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (ret_cnt_q == k_q) begin
          if (lat_cnt_q == LAT_W'(LAT_LAST)) begin
            state_d = S_OUTPUT;
          end else begin
            lat_cnt_d = lat_cnt_q + LAT_W'(1);
          end
        end
      end
      S_OUTPUT: begin
        if (res_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (mac_en_c) begin
      ret_cnt_d = ret_cnt_q + K_WIDTH'(1);
    end
    // Returns still in flight from an abandoned job are dropped silently.
    if (rd_data_valid_i && !mac_en_c && !drop_q) begin
      proto_err_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      k_q            <= '0;
      issue_cnt_q    <= '0;
      ret_cnt_q      <= '0;
      lat_cnt_q      <= '0;
      addr_a_q       <= '0;
      addr_b_q       <= '0;
      proto_err_q    <= 1'b0;
      drop_q         <= 1'b1;
      rd_req_valid_q <= 1'b0;
      mac_clear_q    <= 1'b0;
      res_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
      cmd_ready_q    <= 1'b1;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      issue_cnt_q    <= issue_cnt_d;
      ret_cnt_q      <= ret_cnt_d;
      lat_cnt_q      <= lat_cnt_d;
      addr_a_q       <= addr_a_d;
      addr_b_q       <= addr_b_d;
      proto_err_q    <= proto_err_d;
      drop_q         <= drop_d;
      rd_req_valid_q <= (state_d == S_ISSUE);
      mac_clear_q    <= (state_d == S_CLEAR);
      res_valid_q    <= (state_d == S_OUTPUT);
      busy_q         <= (state_d != S_IDLE);
      cmd_ready_q    <= (state_d == S_IDLE);
    end
  end

  assign cmd_ready_o    = cmd_ready_q;
  assign rd_req_valid_o = rd_req_valid_q;
  assign rd_addr_a_o    = addr_a_q;
  assign rd_addr_b_o    = addr_b_q;
  assign mac_clear_o    = mac_clear_q;
  assign mac_enable_o   = mac_en_c;
  assign res_valid_o    = res_valid_q;
  assign busy_o         = busy_q;
  assign proto_err_o    = proto_err_q;

endmodule

// File: tb/tb_matrix_mac_sequencer.sv
// Directed scoreboard bench for matrix_mac_sequencer: a one-cycle-latency tile buffer
// responder and a queue of expected request addresses checked at every handshake.
module tb_matrix_mac_sequencer;

  localparam int unsigned AW = 10;
  localparam int unsigned KW = 8;
  localparam int unsigned ML = 1;

  logic          clock;
  logic          reset;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [AW-1:0] cmd_a_base_i;
  logic [AW-1:0] cmd_b_base_i;
  logic [KW-1:0] cmd_k_tiles_i;
  logic          rd_req_valid_o;
  logic          rd_req_ready_i;
  logic [AW-1:0] rd_addr_a_o;
  logic [AW-1:0] rd_addr_b_o;
  logic          rd_data_valid_i;
  logic          mac_clear_o;
  logic          mac_enable_o;
  logic          res_valid_o;
  logic          res_ready_i;
  logic          busy_o;
  logic          proto_err_o;

  matrix_mac_sequencer #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (AW),
    .K_WIDTH    (KW),
    .MAC_LATENCY(ML)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_a_base_i   (cmd_a_base_i),
    .cmd_b_base_i   (cmd_b_base_i),
    .cmd_k_tiles_i  (cmd_k_tiles_i),
    .rd_req_valid_o (rd_req_valid_o),
    .rd_req_ready_i (rd_req_ready_i),
    .rd_addr_a_o    (rd_addr_a_o),
    .rd_addr_b_o    (rd_addr_b_o),
    .rd_data_valid_i(rd_data_valid_i),
    .mac_clear_o    (mac_clear_o),
    .mac_enable_o   (mac_enable_o),
    .res_valid_o    (res_valid_o),
    .res_ready_i    (res_ready_i),
    .busy_o         (busy_o),
    .proto_err_o    (proto_err_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  logic [2*AW-1:0] exp_q[$];
  int n_req, n_en, n_clr, n_stall, cyc;
  int clr_cyc, last_ret_cyc, res_cyc;
  logic stall_prev, res_prev;
  logic [2*AW-1:0] stall_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: monitor at the falling edge, then drive the buffer's data return.
  task automatic cycle();
    logic hs;
    logic [2*AW-1:0] e;
    @(negedge clock);
    hs = reset && rd_req_valid_o && rd_req_ready_i;
    if (hs) begin
      n_req++;
      check("req_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("req_addr", 32'({rd_addr_a_o, rd_addr_b_o}), 32'(e));
      end
    end
    if (reset && rd_req_valid_o && !rd_req_ready_i) begin
      if (stall_prev) check("stall_hold", 32'({rd_addr_a_o, rd_addr_b_o}), 32'(stall_addr));
      stall_addr = {rd_addr_a_o, rd_addr_b_o};
      stall_prev = 1'b1;
      n_stall++;
    end else begin
      stall_prev = 1'b0;
    end
    if (mac_enable_o === 1'b1) begin
      n_en++;
      last_ret_cyc = cyc;
    end
    if (mac_clear_o === 1'b1) begin
      n_clr++;
      clr_cyc = cyc;
    end
    if (res_valid_o && !res_prev) res_cyc = cyc;
    res_prev = res_valid_o;
    cyc++;
    @(posedge clock);
    #1;
    rd_data_valid_i = hs;
  endtask

  task automatic start_job(input logic [AW-1:0] a, input logic [AW-1:0] b, input int k);
    logic [AW-1:0] ea, eb;
    n_req = 0; n_en = 0; n_clr = 0; n_stall = 0;
    clr_cyc = -100; last_ret_cyc = -100; res_cyc = -100;
    for (int i = 0; i < k; i++) begin
      ea = a + AW'(i);
      eb = b + AW'(i);
      exp_q.push_back({ea, eb});
    end
    check("idle_cmd_ready", 32'(cmd_ready_o), 32'd1);
    cmd_a_base_i  = a;
    cmd_b_base_i  = b;
    cmd_k_tiles_i = KW'(k);
    cmd_valid_i   = 1'b1;
    cycle();
    cmd_valid_i   = 1'b0;
    check("busy_after_cmd", 32'(busy_o), 32'd1);
    check("cmd_ready_busy", 32'(cmd_ready_o), 32'd0);
  endtask

  task automatic run_job(input logic [AW-1:0] a, input logic [AW-1:0] b, input int k,
                         input bit stall, input int hold, input logic exp_err);
    bit done;
    rd_req_ready_i = !stall;
    start_job(a, b, k);
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (stall && n_stall >= 3) rd_req_ready_i = 1'b1;
      cycle();
      if (res_valid_o) begin
        done = 1'b1;
        break;
      end
    end
    check("job_done", 32'(done), 32'd1);
    for (int i = 0; i < hold; i++) begin
      res_ready_i = 1'b0;
      cycle();
      check("res_hold_valid", 32'(res_valid_o), 32'd1);
      check("res_hold_cmd_ready", 32'(cmd_ready_o), 32'd0);
    end
    res_ready_i = 1'b1;
    cycle();
    res_ready_i = 1'b0;
    rd_req_ready_i = 1'b1;
    check("res_released", 32'(res_valid_o), 32'd0);
    check("cmd_ready_after", 32'(cmd_ready_o), 32'd1);
    check("idle_busy", 32'(busy_o), 32'd0);
    check("n_clear", 32'(n_clr), 32'd1);
    check("n_req", 32'(n_req), 32'(k));
    check("n_mac_enable", 32'(n_en), 32'(k));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    if (k > 0) check("res_latency", 32'(res_cyc - last_ret_cyc), 32'(1 + ML));
    else       check("res_latency_k0", 32'(res_cyc - clr_cyc), 32'(1 + ML));
    if (stall) check("n_stall", 32'(n_stall), 32'd3);
    check("proto_err", 32'(proto_err_o), 32'(exp_err));
  endtask

  initial begin
    reset = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_a_base_i = '0;
    cmd_b_base_i = '0;
    cmd_k_tiles_i = '0;
    rd_req_ready_i = 1'b1;
    rd_data_valid_i = 1'b0;
    res_ready_i = 1'b0;
    n_req = 0; n_en = 0; n_clr = 0; n_stall = 0; cyc = 0;
    clr_cyc = 0; last_ret_cyc = 0; res_cyc = 0;
    stall_prev = 1'b0; res_prev = 1'b0; stall_addr = '0;

    repeat (3) cycle();
    reset = 1'b1;
    check("rst_rd_req_valid", 32'(rd_req_valid_o), 32'd0);
    check("rst_mac_clear", 32'(mac_clear_o), 32'd0);
    check("rst_res_valid", 32'(res_valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    check("rst_proto_err", 32'(proto_err_o), 32'd0);
    cycle();

    run_job(10'h010, 10'h200, 3, 1'b0, 0, 1'b0);
    run_job(10'h020, 10'h120, 2, 1'b1, 4, 1'b0);
    run_job(10'h3FE, 10'h001, 4, 1'b0, 1, 1'b0);
    run_job(10'h055, 10'h0AA, 0, 1'b0, 0, 1'b0);

    // Abandon a K=5 job after two requests.
    start_job(10'h040, 10'h080, 5);
    for (int i = 0; i < 50 && n_req < 2; i++) cycle();
    check("mid_two_reqs", 32'(n_req), 32'd2);
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    exp_q.delete();
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_rd_req_valid", 32'(rd_req_valid_o), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    check("mid_rst_no_more_req", 32'(n_req), 32'd2);
    rd_data_valid_i = 1'b1;
    #1;
    check("stray_after_rst_mac_enable", 32'(mac_enable_o), 32'd0);
    cycle();
    check("stray_after_rst_proto_err", 32'(proto_err_o), 32'd0);
    repeat (3) cycle();
    check("mid_rst_quiet", 32'(n_req), 32'd2);

    run_job(10'h005, 10'h105, 1, 1'b0, 0, 1'b0);

    // A return with nothing outstanding in IDLE is a protocol error.
    rd_data_valid_i = 1'b1;
    #1;
    check("idle_stray_mac_enable", 32'(mac_enable_o), 32'd0);
    cycle();
    check("idle_stray_proto_err", 32'(proto_err_o), 32'd1);
    run_job(10'h300, 10'h310, 2, 1'b0, 2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
